// File: rtl/dadda_pkg.sv
// Shared elaboration-time helpers for the Dadda multiplier. These compute the height
// sequence, the column heights and the cell counts that every reduction level uses.
package dadda_pkg;

  typedef enum int {INFO_H, INFO_FA, INFO_HA} info_e;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Dadda target heights: d1 = 2, d(j+1) = floor(1.5 * d(j)) -> 2,3,4,6,9,13,...
  function automatic int dadda_d(input int j);
    int d = 2;
    for (int i = 1; i < j; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int num_levels(input int max_h);
    int n = 0;
    while (dadda_d(n + 1) < max_h) n++;
    return n;
  endfunction

  function automatic int pp_height(input int w, input int c);
    if (c < 0 || c > 2 * w - 2) return 0;
    return (c < w) ? c + 1 : 2 * w - 1 - c;
  endfunction

  // The compensation bit sits on top of column k-1.
  function automatic int init_height(input int w, input int k, input int c);
    return pp_height(w, c) + ((k > 0 && c == k - 1) ? 1 : 0);
  endfunction

  function automatic int max_height(input int w, input int k);
    int m = 0;
    for (int c = 0; c < 2 * w; c++) if (init_height(w, k, c) > m) m = init_height(w, k, c);
    return m;
  endfunction

  // Column height entering level lvl, or the FA/HA count used in that column at lvl.
  function automatic int tree_info(input int w, input int k, input int lvl, input int c,
                                   input info_e sel);
    int h  [32];
    int nh [32];
    int nl, d, cin, ex, nfa, nha;
    for (int i = 0; i < 32; i++) h[i] = init_height(w, k, i);
    nl = num_levels(max_height(w, k));
    for (int l = 0; l <= lvl; l++) begin
      if (l == lvl && sel == INFO_H) return h[c];
      d   = dadda_d(nl - l);
      cin = 0;
      for (int i = 0; i < 32; i++) nh[i] = h[i];
      for (int i = 0; i < 2 * w; i++) begin
        ex  = h[i] + cin - d;
        nfa = (ex > 0) ? ex / 2 : 0;
        nha = (ex > 0) ? ex % 2 : 0;
        if (l == lvl && i == c) return (sel == INFO_FA) ? nfa : nha;
        nh[i] = h[i] - 2 * nfa - nha + cin;
        cin   = nfa + nha;
      end
      for (int i = 0; i < 32; i++) h[i] = nh[i];
    end
    return 0;
  endfunction

  function automatic int col_off(input int w, input int k, input int lvl, input int c);
    int s = 0;
    for (int i = 0; i < c; i++) s += tree_info(w, k, lvl, i, INFO_H);
    return s;
  endfunction

  function automatic int level_bits(input int w, input int k, input int lvl);
    return col_off(w, k, lvl, 2 * w);
  endfunction

endpackage

// File: rtl/dadda_mult_pipe_reduce_tree.sv
// Combinational Dadda reduction of a WIDTH x WIDTH partial-product matrix (plus one
// compensation bit) down to two rows, built from full/half adder cells.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module dadda_reduce_tree
  import dadda_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int APPROX_COLS = 3
) (
  input  logic [WIDTH*WIDTH-1:0] pp,
  input  logic                   comp,
  output logic [2*WIDTH-1:0]     row0,
  output logic [2*WIDTH-1:0]     row1
);
  localparam int PW = prod_w(WIDTH);
  localparam int K  = APPROX_COLS;
  localparam int NL = num_levels(max_height(WIDTH, K));

  // Each level packs its columns LSB-first; within a column: FA sums, HA sums,
  // pass-through bits, then carries arriving from the column below.
  for (genvar l = 0; l <= NL; l++) begin : lvl
    logic [level_bits(WIDTH, K, l)-1:0] bits;
    if (l == 0) begin : g_init
      for (genvar i = 0; i < WIDTH; i++) begin : g_i
        for (genvar j = 0; j < WIDTH; j++) begin : g_j
          localparam int POS = col_off(WIDTH, K, 0, i + j) + i
                               - ((i + j >= WIDTH) ? i + j - WIDTH + 1 : 0);
          assign bits[POS] = pp[i*WIDTH+j];
        end
      end
      if (K > 0) begin : g_comp
        assign bits[col_off(WIDTH, K, 0, K - 1) + pp_height(WIDTH, K - 1)] = comp;
      end
    end else begin : g_red
      for (genvar c = 0; c < PW; c++) begin : g_col
        localparam int NF = tree_info(WIDTH, K, l - 1, c, INFO_FA);
        localparam int NH = tree_info(WIDTH, K, l - 1, c, INFO_HA);
        localparam int NP = tree_info(WIDTH, K, l - 1, c, INFO_H) - 3 * NF - 2 * NH;
        localparam int IB = col_off(WIDTH, K, l - 1, c);
        localparam int OB = col_off(WIDTH, K, l, c);
        localparam int CN = (c + 1 < PW) ? c + 1 : c;
        localparam int CB = col_off(WIDTH, K, l, CN) + tree_info(WIDTH, K, l - 1, CN, INFO_H)
                            - 2 * tree_info(WIDTH, K, l - 1, CN, INFO_FA)
                            - tree_info(WIDTH, K, l - 1, CN, INFO_HA);
        for (genvar f = 0; f < NF; f++) begin : g_fa
          localparam int X = IB + 3 * f;
          if (c < PW - 1) begin : g_cell
            fa u_fa (.a(lvl[l-1].bits[X]), .b(lvl[l-1].bits[X+1]), .ci(lvl[l-1].bits[X+2]),
                     .s(bits[OB+f]), .co(bits[CB+f]));
          end else begin : g_top
            // Carries out of the top column fall outside the product and are dropped.
            assign bits[OB+f] = lvl[l-1].bits[X] ^ lvl[l-1].bits[X+1] ^ lvl[l-1].bits[X+2];
          end
        end
        for (genvar h = 0; h < NH; h++) begin : g_ha
          localparam int X = IB + 3 * NF + 2 * h;
          if (c < PW - 1) begin : g_cell
            ha u_ha (.a(lvl[l-1].bits[X]), .b(lvl[l-1].bits[X+1]),
                     .s(bits[OB+NF+h]), .co(bits[CB+NF+h]));
          end else begin : g_top
            assign bits[OB+NF+h] = lvl[l-1].bits[X] ^ lvl[l-1].bits[X+1];
          end
        end
        for (genvar p = 0; p < NP; p++) begin : g_pass
          assign bits[OB+NF+NH+p] = lvl[l-1].bits[IB+3*NF+2*NH+p];
        end
      end
    end
  end

  for (genvar c = 0; c < PW; c++) begin : g_out
    localparam int HF = tree_info(WIDTH, K, NL, c, INFO_H);
    localparam int OF = col_off(WIDTH, K, NL, c);
    if (HF > 0) begin : g_r0
      assign row0[c] = lvl[NL].bits[OF];
    end else begin : g_z0
      assign row0[c] = 1'b0;
    end
    if (HF > 1) begin : g_r1
      assign row1[c] = lvl[NL].bits[OF+1];
    end else begin : g_z1
      assign row1[c] = 1'b0;
    end
  end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined unsigned Dadda multiplier with optional truncated/compensated
// approximate mode, valid/ready on both sides and a tag carried with each operation.
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH       = 6,
  parameter int APPROX_COLS = 3,
  parameter int TAG_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic                    in_approx,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_prod,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_approx,
  output logic [1:0]              occupancy
);
  localparam int PW = prod_w(WIDTH);

  logic             s1_valid_q, s1_valid_d, s1_approx_q, s1_approx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d, s2_approx_q, s2_approx_d;
  logic [PW-1:0]    row0_q, row0_d, row1_q, row1_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s3_valid_q, s3_valid_d, s3_approx_q, s3_approx_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [TAG_W-1:0] s3_tag_q, s3_tag_d;
  logic [1:0]       occ_q, occ_d;

  logic                   rdy1, rdy2, rdy3;
  logic [WIDTH*WIDTH-1:0] pp;
  logic                   comp;
  logic [PW-1:0]          tree_row0, tree_row1;

  assign rdy3     = !s3_valid_q || out_ready;
  assign rdy2     = !s2_valid_q || rdy3;
  assign rdy1     = !s1_valid_q || rdy2;
  assign in_ready = rdy1;

  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[i*WIDTH+j] = a_q[i] & b_q[j] & ~(s1_approx_q && (i + j < APPROX_COLS));
  end
  assign comp = s1_approx_q && (APPROX_COLS > 0);

  dadda_reduce_tree #(.WIDTH(WIDTH), .APPROX_COLS(APPROX_COLS)) u_tree (
    .pp   (pp),
    .comp (comp),
    .row0 (tree_row0),
    .row1 (tree_row1)
  );

  always_comb begin
    // NOTE: every _d starts as a copy of its _q, so no path through this block can infer a latch.
    s1_valid_d = s1_valid_q; a_d = a_q; b_d = b_q; s1_approx_d = s1_approx_q; s1_tag_d = s1_tag_q;
    s2_valid_d = s2_valid_q; row0_d = row0_q; row1_d = row1_q;
    s2_approx_d = s2_approx_q; s2_tag_d = s2_tag_q;
    s3_valid_d = s3_valid_q; prod_d = prod_q; s3_approx_d = s3_approx_q; s3_tag_d = s3_tag_q;
    if (rdy1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = in_a; b_d = in_b; s1_approx_d = in_approx; s1_tag_d = in_tag;
      end
    end
    if (rdy2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        row0_d = tree_row0; row1_d = tree_row1; s2_approx_d = s1_approx_q; s2_tag_d = s1_tag_q;
      end
    end
    if (rdy3) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        prod_d = row0_q + row1_q; s3_approx_d = s2_approx_q; s3_tag_d = s2_tag_q;
      end
    end
    occ_d = 2'(s1_valid_d) + 2'(s2_valid_d) + 2'(s3_valid_d);
  end

  // NOTE: state uses non-blocking assignments so all stages update together at the edge;
  // data registers are cleared as well so outputs read zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0; a_q <= '0; b_q <= '0; s1_approx_q <= 1'b0; s1_tag_q <= '0;
      s2_valid_q <= 1'b0; row0_q <= '0; row1_q <= '0; s2_approx_q <= 1'b0; s2_tag_q <= '0;
      s3_valid_q <= 1'b0; prod_q <= '0; s3_approx_q <= 1'b0; s3_tag_q <= '0;
      occ_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d; a_q <= a_d; b_q <= b_d;
      s1_approx_q <= s1_approx_d; s1_tag_q <= s1_tag_d;
      s2_valid_q <= s2_valid_d; row0_q <= row0_d; row1_q <= row1_d;
      s2_approx_q <= s2_approx_d; s2_tag_q <= s2_tag_d;
      s3_valid_q <= s3_valid_d; prod_q <= prod_d;
      s3_approx_q <= s3_approx_d; s3_tag_q <= s3_tag_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_prod   = prod_q;
  assign out_tag    = s3_tag_q;
  assign out_approx = s3_approx_q;
  assign occupancy  = occ_q;

endmodule
